// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 fetch path: NOP encoding, XLEN/ILEN, fetch FSM states.
// Optional build macro IFETCH_FAULT_EN adds the FAULT state.
// Pure definitions, no logic.
package msrv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- presented downstream whenever no instruction is available
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
`ifdef IFETCH_FAULT_EN
        FAULT    = 2'd2,
`endif
        FETCH    = 2'd1
    } fetch_state_t;

endpackage

// File: rtl/msrv32_ifetch_fifo.sv
// Fetch buffer: DEPTH-entry ring of {pc, data, filled[, fault]} with separate alloc / fill / pop pointers.
// Latency: entry contents visible the cycle after fill; the parent provides fill-through for the head.
// Backpressure: none internally; the parent gates alloc by o_alloc_cnt and pop by stall. Macro: IFETCH_FAULT_EN.
module msrv32_ifetch_fifo
    import msrv32_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BOOT_ADDR = '0,
    parameter int               DEPTH     = 2,
    localparam int              AW        = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_alloc,
    input  logic [WIDTH-1:0] i_alloc_pc,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_fill_data,
`ifdef IFETCH_FAULT_EN
    input  logic             i_fill_fault,
    output logic             o_head_fault,
`endif
    input  logic             i_pop,
    output logic [AW:0]      o_alloc_cnt,
    output logic [AW:0]      o_unfilled_cnt,
    output logic             o_head_filled,
    output logic [WIDTH-1:0] o_head_pc,
    output logic [WIDTH-1:0] o_head_data
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      r_head;
    logic [AW:0]      r_fill;
    logic [AW:0]      r_tail;
    logic [WIDTH-1:0] r_pc   [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
`ifdef IFETCH_FAULT_EN
    logic [DEPTH-1:0] r_fault;
`endif

    logic w_fill_ok;

    // A response can only land on an allocated entry that is still waiting for data
    assign w_fill_ok      = i_fill & (r_fill != r_tail);
    assign o_alloc_cnt    = r_tail - r_head;
    assign o_unfilled_cnt = r_tail - r_fill;
    assign o_head_filled  = (o_alloc_cnt != '0) & r_filled[r_head[AW-1:0]];
    assign o_head_pc      = r_pc[r_head[AW-1:0]];
    assign o_head_data    = r_data[r_head[AW-1:0]];
`ifdef IFETCH_FAULT_EN
    assign o_head_fault   = r_fault[r_head[AW-1:0]];
`endif

    // Ring update: clear wins; otherwise alloc at tail, fill at oldest unfilled, pop at head
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head   <= '0;
            r_fill   <= '0;
            r_tail   <= '0;
            r_filled <= '0;
`ifdef IFETCH_FAULT_EN
            r_fault  <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= BOOT_ADDR;
                r_data[i] <= WIDTH'(NOP);
            end
        end else if (i_clear) begin
            r_head   <= '0;
            r_fill   <= '0;
            r_tail   <= '0;
            r_filled <= '0;
        end else begin
            if (i_alloc) begin
                r_pc[r_tail[AW-1:0]]     <= i_alloc_pc;
                r_filled[r_tail[AW-1:0]] <= 1'b0;
`ifdef IFETCH_FAULT_EN
                r_fault[r_tail[AW-1:0]]  <= 1'b0;
`endif
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_fill_ok) begin
                r_data[r_fill[AW-1:0]]   <= i_fill_data;
                r_filled[r_fill[AW-1:0]] <= 1'b1;
`ifdef IFETCH_FAULT_EN
                r_fault[r_fill[AW-1:0]]  <= i_fill_fault;
`endif
                r_fill <= r_fill + PTR_ONE;
            end
            if (i_pop) begin
                r_head <= r_head + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/msrv32_ifetch_unit.sv
// Instruction fetch: owns fetch PC, issues req/gnt/rvalid word fetches, buffers words, feeds the instruction mux.
// Latency: gnt in N, rvalid in N+1 -> instr_valid_out in N+1 (head fill-through); up to DEPTH words in flight.
// Backpressure: stall_in holds the head; requests stop once DEPTH entries are allocated. Macro: IFETCH_FAULT_EN.
module msrv32_ifetch_unit
    import msrv32_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BOOT_ADDR = '0,
    parameter int               DEPTH     = 2
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    output logic             imem_req_out,
    output logic [WIDTH-1:0] imem_addr_out,
    input  logic             imem_gnt_in,
    input  logic             imem_rvalid_in,
    input  logic [WIDTH-1:0] imem_rdata_in,
`ifdef IFETCH_FAULT_EN
    input  logic             imem_err_in,
    output logic             instr_fault_out,
`endif
    input  logic             redirect_in,
    input  logic [WIDTH-1:0] redirect_pc_in,
    input  logic             stall_in,
    output logic             instr_valid_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_out,
    output logic             flush_out
);

    localparam int          AW        = $clog2(DEPTH);
    // Discards can stack across back-to-back redirects, so leave headroom above DEPTH
    localparam int          DCW       = AW + 4;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [DCW-1:0]   r_discard_cnt;

    logic [AW:0]      w_alloc_cnt;
    logic [AW:0]      w_unfilled_cnt;
    logic             w_head_filled;
    logic [WIDTH-1:0] w_head_pc;
    logic [WIDTH-1:0] w_head_data;
    logic             w_alloc;
    logic             w_fill;
    logic             w_bypass;
    logic             w_pop;
    logic [WIDTH-1:0] w_fill_data;
    logic [DCW-1:0]   w_inflight;
`ifdef IFETCH_FAULT_EN
    logic             w_fill_err;
    logic             w_head_fault;
`endif

    assign imem_req_out  = (r_state == FETCH) & (w_alloc_cnt < DEPTH_CNT) & ~redirect_in;
    assign imem_addr_out = r_fetch_pc;
    assign w_alloc       = imem_req_out & imem_gnt_in;

    // A response is kept only when nothing stale is ahead of it and no redirect is flushing this cycle
    assign w_fill   = imem_rvalid_in & (r_discard_cnt == '0) & ~redirect_in & (w_unfilled_cnt != '0);
    // Head still empty and this response is its data: present it straight from the bus
    assign w_bypass = w_fill & (w_unfilled_cnt == w_alloc_cnt);

`ifdef IFETCH_FAULT_EN
    assign w_fill_err      = w_fill & imem_err_in;
    assign w_fill_data     = imem_err_in ? WIDTH'(NOP) : imem_rdata_in;
    assign instr_fault_out = w_head_filled ? w_head_fault : (w_bypass & imem_err_in);
`else
    assign w_fill_data     = imem_rdata_in;
`endif

    assign instr_valid_out = w_head_filled | w_bypass;
    assign instr_out       = w_head_filled ? w_head_data : (w_bypass ? w_fill_data : WIDTH'(NOP));
    assign pc_out          = w_head_pc;
    assign flush_out       = ~instr_valid_out | redirect_in;
    assign w_pop           = instr_valid_out & ~stall_in & ~redirect_in;

    // Everything requested but not yet returned: already-stale responses plus live unfilled entries
    assign w_inflight = r_discard_cnt + DCW'(w_unfilled_cnt);

    // Fetch FSM: one idle cycle after reset, then fetch; redirect always lands in FETCH
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= RST_WAIT;
        end else if (redirect_in) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                RST_WAIT: r_state <= FETCH;
`ifdef IFETCH_FAULT_EN
                FETCH:    if (w_fill_err) r_state <= FAULT;
                FAULT:    r_state <= FAULT;
`else
                FETCH:    r_state <= FETCH;
`endif
                default:  r_state <= RST_WAIT;
            endcase
        end
    end

    // Fetch PC: word-aligned redirect target, else advance one word per accepted request
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_fetch_pc <= BOOT_ADDR;
        end else if (redirect_in) begin
            r_fetch_pc <= redirect_pc_in & ~WIDTH'(3);
        end else if (w_alloc) begin
            r_fetch_pc <= r_fetch_pc + WIDTH'(4);
        end
    end

    // Discard counter: on redirect all in-flight responses become stale, less one returning right now
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_discard_cnt <= '0;
        end else if (redirect_in) begin
            r_discard_cnt <= (imem_rvalid_in && w_inflight != '0) ? w_inflight - DCW'(1) : w_inflight;
        end else if (imem_rvalid_in && r_discard_cnt != '0) begin
            r_discard_cnt <= r_discard_cnt - DCW'(1);
        end
    end

    msrv32_ifetch_fifo #(
        .WIDTH     (WIDTH),
        .BOOT_ADDR (BOOT_ADDR),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .i_clk          (ms_riscv32_mp_clk_in),
        .i_rst          (ms_riscv32_mp_rst_in),
        .i_clear        (redirect_in),
        .i_alloc        (w_alloc),
        .i_alloc_pc     (r_fetch_pc),
        .i_fill         (w_fill),
        .i_fill_data    (w_fill_data),
`ifdef IFETCH_FAULT_EN
        .i_fill_fault   (imem_err_in),
        .o_head_fault   (w_head_fault),
`endif
        .i_pop          (w_pop),
        .o_alloc_cnt    (w_alloc_cnt),
        .o_unfilled_cnt (w_unfilled_cnt),
        .o_head_filled  (w_head_filled),
        .o_head_pc      (w_head_pc),
        .o_head_data    (w_head_data)
    );

endmodule

// File: tb/tb_msrv32_ifetch_unit.sv
// Bench for msrv32_ifetch_unit: random memory/stall/redirect traffic against a generation-tagged reference model.
// The model tracks the expected fetch PC, allocated-entry queue and live responses; outputs are compared each cycle.
// Directed phases pin reset values, fill-through latency, redirect discard, alignment, PC wrap and mid-burst reset.
module tb_msrv32_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        stall_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        flush_out;
`ifdef IFETCH_FAULT_EN
    logic        imem_err_in;
    logic        instr_fault_out;
    initial imem_err_in = 1'b0;
`endif

    msrv32_ifetch_unit #(.WIDTH(32), .BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_gnt_in          (imem_gnt_in),
        .imem_rvalid_in       (imem_rvalid_in),
        .imem_rdata_in        (imem_rdata_in),
`ifdef IFETCH_FAULT_EN
        .imem_err_in          (imem_err_in),
        .instr_fault_out      (instr_fault_out),
`endif
        .redirect_in          (redirect_in),
        .redirect_pc_in       (redirect_pc_in),
        .stall_in             (stall_in),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .pc_out               (pc_out),
        .flush_out            (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          ready;
    } rsp_t;

    rsp_t        mem_q[$];     // granted requests awaiting their response, in order
    logic [31:0] buf_q[$];     // PCs of entries allocated since last redirect/reset, not yet popped
    int          filled_m;     // how many of buf_q's oldest entries already have data
    int          gen;          // bumped on redirect/reset; responses of older generations are stale
    logic [31:0] fetch_pc_m;
    bit          fetch_mode;   // false only during the first cycle after reset

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int since_rst = 0;

    // stimulus controls
    bit          drv_redirect = 0;
    logic [31:0] drv_redirect_pc = '0;
    bit          drv_stall = 0;
    bit          drv_force_rv = 0;
    bit          drv_stale = 0;
    bit          rnd_mode = 0;
    int          gnt_pct = 100;
    int          rv_pct = 100;
    int          stall_pct = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    // per-cycle model values
    bit s_rv, s_stale, exp_req, exp_valid, exp_pop, live;
    logic last_req;

    // captures for literal checks
    bit          cap_on = 0;
    int          cap_n = 0;
    int          cap_cyc0 = 0;
    logic [31:0] cap_addr [3];
    bit          fv_armed = 0;
    logic [31:0] fv_pc = '1;
    int          fv_cyc = -1;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1000_0001;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].gen == gen) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        exp_req   = fetch_mode && (buf_q.size() < DEPTH) && !redirect_in;
        live      = s_rv && !s_stale && !redirect_in && (mem_q[0].gen == gen);
        exp_valid = (filled_m > 0) || live;
        exp_pop   = exp_valid && !stall_in && !redirect_in;
        last_req  = imem_req_out;
        chk("req", {31'b0, imem_req_out}, {31'b0, exp_req});
        if (exp_req) chk("addr", imem_addr_out, fetch_pc_m);
        chk("valid", {31'b0, instr_valid_out}, {31'b0, exp_valid});
        chk("flush", {31'b0, flush_out}, {31'b0, (!exp_valid || redirect_in)});
        if (exp_valid) begin
            chk("pc", pc_out, buf_q[0]);
            chk("instr", instr_out, memword(buf_q[0]));
        end else begin
            chk("instr_nop", instr_out, NOP);
        end
        if (cap_on && imem_req_out && cap_n < 3) begin
            if (cap_n == 0) cap_cyc0 = since_rst;
            cap_addr[cap_n] = imem_addr_out;
            cap_n++;
        end
        if (fv_armed && instr_valid_out) begin
            fv_pc    = pc_out;
            fv_cyc   = since_rst;
            fv_armed = 0;
        end
    endtask

    task automatic update();
        rsp_t r;
        if (redirect_in) begin
            if (s_rv && !s_stale) void'(mem_q.pop_front());
            gen++;
            buf_q.delete();
            filled_m   = 0;
            fetch_pc_m = redirect_pc_in & 32'hFFFF_FFFC;
            fetch_mode = 1;
        end else begin
            if (s_rv && !s_stale) begin
                if (mem_q[0].gen == gen) filled_m++;
                void'(mem_q.pop_front());
            end
            if (exp_req && imem_gnt_in) begin
                r.addr  = fetch_pc_m;
                r.gen   = gen;
                r.ready = cyc + int'($urandom_range(lat_max, lat_min));
                mem_q.push_back(r);
                buf_q.push_back(fetch_pc_m);
                fetch_pc_m = fetch_pc_m + 32'd4;
            end
            if (exp_pop) begin
                void'(buf_q.pop_front());
                filled_m--;
            end
            fetch_mode = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        redirect_in    = drv_redirect;
        redirect_pc_in = drv_redirect_pc;
        stall_in       = drv_stall;
        if (rnd_mode) begin
            redirect_in    = ($urandom_range(99) < 4);
            redirect_pc_in = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            stall_in       = ($urandom_range(99) < stall_pct);
        end
        imem_gnt_in = ($urandom_range(99) < gnt_pct);
        s_stale = drv_stale;
        s_rv    = drv_stale;
        if (!drv_stale && mem_q.size() > 0 && mem_q[0].ready <= cyc &&
            (drv_force_rv || $urandom_range(99) < rv_pct))
            s_rv = 1;
        imem_rvalid_in = s_rv;
        imem_rdata_in  = (s_rv && !s_stale) ? memword(mem_q[0].addr) : $urandom;
        #2;
        compare();
        @(posedge clk);
        update();
        cyc++;
        since_rst++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        redirect_in    = 0;
        stall_in       = 0;
        imem_gnt_in    = 0;
        imem_rvalid_in = 0;
        #3 rst = 1;
        #1;
        chk("rst_req",   {31'b0, imem_req_out},    32'd0);
        chk("rst_addr",  imem_addr_out,            BOOT);
        chk("rst_valid", {31'b0, instr_valid_out}, 32'd0);
        chk("rst_instr", instr_out,                NOP);
        chk("rst_pc",    pc_out,                   BOOT);
        chk("rst_flush", {31'b0, flush_out},       32'd1);
        gen++;
        mem_q.delete();
        buf_q.delete();
        filled_m   = 0;
        fetch_pc_m = BOOT;
        fetch_mode = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        since_rst = 1;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bit ok;
        rst = 1; gen = 0; filled_m = 0; fetch_pc_m = BOOT; fetch_mode = 0;
        redirect_in = 0; redirect_pc_in = '0; stall_in = 0;
        imem_gnt_in = 0; imem_rvalid_in = 0; imem_rdata_in = '0;

        // A: reset then zero-wait memory, no stall
        apply_reset();
        cap_on = 1; cap_n = 0; fv_armed = 1;
        repeat (20) step();
        cap_on = 0;
        chk("a_first_req_cycle", cap_cyc0, 32'd2);
        chk("a_addr0", cap_addr[0], 32'h0);
        chk("a_addr1", cap_addr[1], 32'h4);
        chk("a_addr2", cap_addr[2], 32'h8);
        chk("a_first_valid_cycle", fv_cyc, 32'd3);
        chk("a_first_valid_pc", fv_pc, 32'h0);

        // B: stall held five cycles, then released
        drv_stall = 1;
        repeat (5) step();
        chk("b_stall_req_off", {31'b0, last_req}, 32'd0);
        drv_stall = 0;
        repeat (10) step();

        // C: two requests outstanding, redirect to 0x100
        lat_min = 4; lat_max = 4;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (buf_q.size() == 2 && filled_m == 0 && live_cnt() == 2) ok = 1;
            else step();
        end
        chk("c_setup_reached", {31'b0, ok}, 32'd1);
        drv_redirect = 1; drv_redirect_pc = 32'h100;
        step();
        drv_redirect = 0;
        fv_armed = 1;
        repeat (15) step();
        chk("c_first_pc_after_redirect", fv_pc, 32'h100);

        // D: misaligned redirect coinciding with a response
        lat_min = 2; lat_max = 2;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (mem_q.size() > 0 && mem_q[0].ready <= cyc) ok = 1;
            else step();
        end
        chk("d_setup_reached", {31'b0, ok}, 32'd1);
        drv_redirect = 1; drv_redirect_pc = 32'h203; drv_force_rv = 1;
        step();
        drv_redirect = 0; drv_force_rv = 0;
        cap_on = 1; cap_n = 0; fv_armed = 1;
        repeat (10) step();
        cap_on = 0;
        chk("d_aligned_addr", cap_addr[0], 32'h200);
        chk("d_first_pc", fv_pc, 32'h200);

        // E: fetch PC wrap at the top of the address space
        lat_min = 1; lat_max = 1;
        drv_redirect = 1; drv_redirect_pc = 32'hFFFF_FFF8;
        step();
        drv_redirect = 0;
        cap_on = 1; cap_n = 0;
        repeat (8) step();
        cap_on = 0;
        chk("e_addr0", cap_addr[0], 32'hFFFF_FFF8);
        chk("e_addr1", cap_addr[1], 32'hFFFF_FFFC);
        chk("e_addr2", cap_addr[2], 32'h0000_0000);

        // F: random traffic
        rnd_mode = 1; gnt_pct = 70; rv_pct = 70; stall_pct = 30; lat_min = 1; lat_max = 4;
        repeat (1500) step();

        // G: reset in the middle of a burst, stale response right after release
        rnd_mode = 0; gnt_pct = 100; rv_pct = 100; stall_pct = 0; lat_min = 3; lat_max = 3;
        repeat (4) step();
        apply_reset();
        drv_stale = 1; rnd_mode = 1; stall_pct = 20; gnt_pct = 80; rv_pct = 80; lat_min = 1; lat_max = 3;
        step();
        drv_stale = 0;
        repeat (500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
